// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial frame transmitter: start, LSB-first data, optional
// even parity, stop. All outputs are registered.
module par_to_ser_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              serial_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int IW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [7:0]    CNT_MAX = 8'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              serial_q, serial_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      bit_end = (cnt_q == CNT_MAX);

      if (state_q != IDLE) begin
         cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (valid_i && ready_q) begin
               state_d = START;
               shift_d = data_i;
               par_d   = ^data_i;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_MAX) begin
                  idx_d   = '0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are precomputed from the next state so they stay registered
      ready_d = (state_d == IDLE);
      busy_d  = !ready_d;
      unique case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
         PARITY:  serial_d = par_q;
         default: serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign ready_o  = ready_q;
   assign serial_o = serial_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Directed bench for par_to_ser_tx: default build plus a
// BIT_CYCLES=1 / no-parity variant.
module tb_par_to_ser_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data, v_data;
   logic       valid, v_valid;
   logic       ready, serial, busy, done;
   logic       v_ready, v_serial, v_busy, v_done;

   int total = 0;
   int bad   = 0;

   logic sm [0:63];
   logic sv [0:63];
   int   busy_lo_m, done_m, busy_lo_v, done_v;

   always #5 clk = ~clk;

   par_to_ser_tx u_dut (
      .clk      (clk),
      .reset    (reset),
      .data_i   (data),
      .valid_i  (valid),
      .ready_o  (ready),
      .serial_o (serial),
      .busy_o   (busy),
      .done_o   (done)
   );

   par_to_ser_tx #(
      .DATA_W     (8),
      .BIT_CYCLES (1),
      .PARITY_EN  (0)
   ) u_var (
      .clk      (clk),
      .reset    (reset),
      .data_i   (v_data),
      .valid_i  (v_valid),
      .ready_o  (v_ready),
      .serial_o (v_serial),
      .busy_o   (v_busy),
      .done_o   (v_done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int n, input bit disturb);
      busy_lo_m = 0;
      done_m    = 0;
      busy_lo_v = 0;
      done_v    = 0;
      for (int i = 0; i < n; i++) begin
         sm[i] = serial;
         sv[i] = v_serial;
         if (!busy)   busy_lo_m++;
         if (done)    done_m++;
         if (!v_busy) busy_lo_v++;
         if (v_done)  done_v++;
         if (disturb) begin
            valid = (i % 2 == 1);
            data  = ~data;
         end
         step();
      end
   endtask

   task automatic check_frame(input string tag, input logic [10:0] exp,
                              input int nb, input int bc, input bit vsel);
      logic got;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < bc; k++) begin
            got = vsel ? sv[b*bc+k] : sm[b*bc+k];
            check($sformatf("%s bit%0d c%0d", tag, b, k), {31'd0, got},
                  {31'd0, exp[b]});
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      valid   = 1'b1;
      data    = 8'hA5;
      v_valid = 1'b1;
      v_data  = 8'h81;

      for (int c = 0; c < 2; c++) begin
         step();
         check("rst serial", {31'd0, serial}, 32'd1);
         check("rst ready",  {31'd0, ready},  32'd1);
         check("rst busy",   {31'd0, busy},   32'd0);
         check("rst done",   {31'd0, done},   32'd0);
         check("rst vbusy",  {31'd0, v_busy}, 32'd0);
      end
      reset   = 1'b0;
      valid   = 1'b0;
      v_valid = 1'b0;
      step();
      check("post rst busy",  {31'd0, busy},   32'd0);
      check("post rst vbusy", {31'd0, v_busy}, 32'd0);

      // single A5 frame
      data  = 8'hA5;
      valid = 1'b1;
      step();
      valid = 1'b0;
      collect(44, 1'b0);
      check_frame("a5", 11'b1_0_10100101_0, 11, 4, 1'b0);
      check("a5 busy gaps", busy_lo_m, 0);
      check("a5 early done", done_m, 0);
      check("a5 done", {31'd0, done},   32'd1);
      check("a5 ready", {31'd0, ready}, 32'd1);
      check("a5 busy end", {31'd0, busy}, 32'd0);
      check("a5 idle serial", {31'd0, serial}, 32'd1);
      step();
      check("a5 done once", {31'd0, done}, 32'd0);

      // back-to-back 00 then FF with valid held high
      data  = 8'h00;
      valid = 1'b1;
      step();
      data = 8'hFF;
      collect(44, 1'b0);
      check_frame("b00", 11'b1_0_00000000_0, 11, 4, 1'b0);
      check("b00 early done", done_m, 0);
      check("b00 done", {31'd0, done}, 32'd1);
      check("b2b gap serial", {31'd0, serial}, 32'd1);
      check("b2b gap ready", {31'd0, ready}, 32'd1);
      step();
      valid = 1'b0;
      collect(44, 1'b0);
      check_frame("bff", 11'b1_0_11111111_0, 11, 4, 1'b0);
      check("bff busy gaps", busy_lo_m, 0);
      check("bff early done", done_m, 0);
      check("bff done", {31'd0, done}, 32'd1);
      step();
      check("bff idle busy", {31'd0, busy}, 32'd0);

      // reset during data bit 3
      data  = 8'h00;
      valid = 1'b1;
      step();
      valid = 1'b0;
      repeat (17) step();
      check("mid bit3 serial", {31'd0, serial}, 32'd0);
      check("mid bit3 busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort serial", {31'd0, serial}, 32'd1);
      check("abort ready", {31'd0, ready}, 32'd1);
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      collect(50, 1'b0);
      check("abort no done", done_m, 0);
      check("abort stays idle", busy_lo_m, 50);

      // 3C frame with valid/data churn while busy
      data  = 8'h3C;
      valid = 1'b1;
      step();
      collect(44, 1'b1);
      valid = 1'b0;
      check_frame("c3c", 11'b1_0_00111100_0, 11, 4, 1'b0);
      check("c3c busy gaps", busy_lo_m, 0);
      check("c3c early done", done_m, 0);
      check("c3c done", {31'd0, done}, 32'd1);
      step();
      collect(10, 1'b0);
      check("no extra frame", busy_lo_m, 10);
      check("no extra done", done_m, 0);

      // variant: one cycle per bit, no parity
      v_data  = 8'h81;
      v_valid = 1'b1;
      step();
      v_valid = 1'b0;
      collect(10, 1'b0);
      check_frame("v81", 11'b0_1_10000001_0, 10, 1, 1'b1);
      check("v81 busy gaps", busy_lo_v, 0);
      check("v81 early done", done_v, 0);
      check("v81 done", {31'd0, v_done}, 32'd1);
      check("v81 idle serial", {31'd0, v_serial}, 32'd1);
      step();
      check("v81 done once", {31'd0, v_done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/par_to_ser_tx.md
PAR_TO_SER_TX -- requirements
Module: par_to_ser_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the payload width in bits (legal range 2..16).
REQ-002 SHALL have parameter BIT_CYCLES, default 4, meaning the clock cycles each serial bit is held (legal range 1..255).
REQ-003 SHALL have parameter PARITY_EN, default 1, meaning an even-parity bit is sent when 1 and omitted when 0.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  DATA_W  the parallel word to transmit.
REQ-007 SHALL have port valid_i  input  1  data_i is valid this cycle.
REQ-008 SHALL have port ready_o  output  1  the block accepts a word this cycle.
REQ-009 SHALL have port serial_o  output  1  the serial line; idles high.
REQ-010 SHALL have port busy_o  output  1  a frame is in progress.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive all outputs from registers; there SHALL be no combinational path from any input to any output.
REQ-014 SHALL assert ready_o only in IDLE.
REQ-015 SHALL define acceptance as valid_i=1 and ready_o=1 at a rising edge; data_i SHALL be captured into a shift register at that edge.
REQ-016 SHALL ignore valid_i when ready_o=0; data_i changes during a frame SHALL NOT affect that frame.
REQ-017 SHALL enter START on the edge of acceptance, so the first start-bit cycle is the cycle after acceptance.
REQ-018 SHALL drive serial_o=0 for BIT_CYCLES cycles in START.
REQ-019 SHALL send DATA_W data bits in DATA, LSB first, each held BIT_CYCLES cycles.
REQ-020 SHALL, when PARITY_EN=1, send in PARITY for BIT_CYCLES cycles the XOR of all captured data bits (even parity).
REQ-021 SHALL, when PARITY_EN=0, go directly from DATA to STOP.
REQ-022 SHALL drive serial_o=1 for BIT_CYCLES cycles in STOP, then return to IDLE.
REQ-023 SHALL make the frame length (2 + DATA_W + PARITY_EN) * BIT_CYCLES cycles, from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-024 SHALL pulse done_o for exactly one cycle, namely the first cycle back in IDLE after STOP.
REQ-025 SHALL assert busy_o in START, DATA, PARITY and STOP, and deassert it in IDLE.
REQ-026 SHALL keep serial_o=1 in IDLE.
REQ-027 SHALL, in the done_o cycle (ready_o=1), accept a new word if valid_i=1, so back-to-back frames have exactly one idle-high cycle between the stop bit and the next start bit.
REQ-028 SHALL count bit cycles with a counter that runs from 0 to BIT_CYCLES-1 and wraps to 0 at each bit boundary.
REQ-029 SHALL count bits with a separate index that runs from 0 to DATA_W-1 in DATA.
REQ-030 SHALL handle BIT_CYCLES=1 without stalls or extra cycles.

Reset
REQ-031 SHALL, when reset=1 at a rising edge, set state=IDLE, serial_o=1, ready_o=1, busy_o=0, done_o=0, and clear both counters and the shift register.
REQ-032 SHALL give reset priority over acceptance; reset in the middle of a frame SHALL abort the frame immediately with no done_o pulse.
REQ-033 SHALL NOT accept any word in a cycle where reset=1.

Verification
REQ-034 SHALL cover reset: reset=1 for 2 cycles with valid_i=1 -> serial_o=1, ready_o=1, busy_o=0, done_o=0, and no frame starts.
REQ-035 SHALL cover a single frame: defaults, data_i=8'hA5, valid_i for 1 cycle -> serial_o per 4-cycle bit reads 0,1,0,1,0,0,1,0,1,0(parity),1(stop); frame lasts 44 cycles; done_o pulses once on cycle 45.
REQ-036 SHALL cover back-to-back frames: valid_i held high with 8'h00 then 8'hFF -> parity 0 then 0; exactly one idle-high cycle between the two frames; two done_o pulses.
REQ-037 SHALL cover a mid-frame reset: reset asserted during DATA bit 3 -> serial_o=1 and ready_o=1 the next cycle, no done_o, and a following 8'h3C frame is sent intact.
REQ-038 SHALL cover a variant configuration: BIT_CYCLES=1, PARITY_EN=0, data_i=8'h81 -> serial_o reads 0,1,0,0,0,0,0,0,1,1 over 10 cycles.
REQ-039 SHALL cover busy-time inputs: valid_i pulsed and data_i toggled during busy_o=1 -> no effect on the current frame and no extra frame.
